// File: rtl/ins_profiler.sv
// ins_profiler: non-intrusive profiler for the retired-instruction stream of
// the R/I/J MIPS core. Classifies each valid instruction and counts classes
// in saturating counters. Counter 7 counts load-use hazards found over a
// HAZ_DIST-deep history window. All counters are visible through a
// registered read port.
`timescale 1ns/1ps

module ins_profiler #(
    parameter int CNT_W    = 32,
    parameter int HAZ_DIST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ins_valid,
    input  logic [31:0]      ins,
    input  logic             clear,
    input  logic [2:0]       rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic             cls_valid,
    output logic [2:0]       cls,
    output logic             hazard,
    output logic             sat
);

    typedef enum logic [2:0] {
        CLS_ALUR   = 3'd0,
        CLS_ALUIMM = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_JUMP   = 3'd5,
        CLS_OTHER  = 3'd6
    } cls_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Instruction fields
    logic [5:0] w_op;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic [5:0] w_funct;
    logic       w_unused;

    assign w_op     = ins[31:26];
    assign w_rs     = ins[25:21];
    assign w_rt     = ins[20:16];
    assign w_funct  = ins[5:0];
    // rd and shamt never influence class or source registers
    assign w_unused = ^ins[15:6];

    cls_e       w_cls;
    logic       w_rd_rs;
    logic       w_rd_rt;
    logic       w_is_load;
    logic       w_hazard;
    logic [7:0] w_inc;
    logic [7:0] w_full;
    logic       w_sat_hit;

    logic             r_hist_ld [HAZ_DIST];
    logic [4:0]       r_hist_rt [HAZ_DIST];
    logic [CNT_W-1:0] r_cnt     [8];
    logic [CNT_W-1:0] r_rd_data;
    logic             r_cls_valid;
    logic [2:0]       r_cls;
    logic             r_hazard;
    logic             r_sat;

    // Decode class and which source registers the instruction reads
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_cls     = CLS_OTHER;
        w_rd_rs   = 1'b0;
        w_rd_rt   = 1'b0;
        w_is_load = 1'b0;
        case (w_op)
            6'b000000: begin
                if (w_funct == 6'b001000) begin
                    w_cls   = CLS_JUMP;       // jr reads rs only
                    w_rd_rs = 1'b1;
                end else begin
                    w_cls   = CLS_ALUR;
                    w_rd_rs = 1'b1;
                    w_rd_rt = 1'b1;
                end
            end
            6'b001000, 6'b001100, 6'b001110, 6'b001011: begin
                w_cls   = CLS_ALUIMM;
                w_rd_rs = 1'b1;
            end
            6'b100011: begin
                w_cls     = CLS_LOAD;
                w_rd_rs   = 1'b1;
                w_is_load = 1'b1;
            end
            6'b101011: begin
                w_cls   = CLS_STORE;
                w_rd_rs = 1'b1;
                w_rd_rt = 1'b1;
            end
            6'b000100, 6'b000101: begin
                w_cls   = CLS_BRANCH;
                w_rd_rs = 1'b1;
                w_rd_rt = 1'b1;
            end
            6'b000010, 6'b000011: w_cls = CLS_JUMP;
            default:              w_cls = CLS_OTHER;
        endcase
    end

    // Load-use match of a non-zero source register against any history load
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < HAZ_DIST; i++) begin
            if (r_hist_ld[i] && (r_hist_rt[i] != 5'd0) &&
                ((w_rd_rs && (w_rs == r_hist_rt[i])) ||
                 (w_rd_rt && (w_rt == r_hist_rt[i])))) begin
                w_hazard = 1'b1;
            end
        end
    end

    // Per-counter increment requests and all-ones detection
    always_comb begin
        w_inc  = '0;
        w_full = '0;
        if (ins_valid) begin
            w_inc[w_cls] = 1'b1;
            w_inc[7]     = w_hazard;
        end
        for (int i = 0; i < 8; i++) begin
            w_full[i] = (r_cnt[i] == CNT_MAX);
        end
    end

    assign w_sat_hit = |(w_inc & w_full);

    // History shifts only on valid instructions, so bubbles do not age it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HAZ_DIST; i++) begin
                r_hist_ld[i] <= 1'b0;
                r_hist_rt[i] <= 5'd0;
            end
        end else if (ins_valid) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            for (int i = HAZ_DIST - 1; i > 0; i--) begin
                r_hist_ld[i] <= r_hist_ld[i-1];
                r_hist_rt[i] <= r_hist_rt[i-1];
            end
            r_hist_ld[0] <= w_is_load;
            r_hist_rt[0] <= w_rt;
        end
    end

    // Saturating event counters and sticky saturation flag; clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the counter array is plain flops, not RAM, and must read back 0 after reset, so every entry is reset.
            for (int i = 0; i < 8; i++) r_cnt[i] <= '0;
            r_sat <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < 8; i++) r_cnt[i] <= '0;
            r_sat <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (w_inc[i] && !w_full[i]) r_cnt[i] <= r_cnt[i] + CNT_ONE;
            end
            if (w_sat_hit) r_sat <= 1'b1;
        end
    end

    // Registered read port and per-instruction classification result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data   <= '0;
            r_cls_valid <= 1'b0;
            r_cls       <= 3'd0;
            r_hazard    <= 1'b0;
        end else begin
            r_rd_data   <= r_cnt[rd_sel];
            r_cls_valid <= ins_valid;
            if (ins_valid) begin
                r_cls    <= w_cls;
                r_hazard <= w_hazard;
            end
        end
    end

    assign rd_data   = r_rd_data;
    assign cls_valid = r_cls_valid;
    assign cls       = r_cls;
    assign hazard    = r_hazard;
    assign sat       = r_sat;

endmodule
